// File: rtl/edge_arb_pkg.sv
// Shared definitions for the edge-event arbiter: scheduler states and sizing limits.
package edge_arb_pkg;

    // Upper bound on the number of level channels the arbiter supports.
    localparam int unsigned MAX_N = 16;

    // Scheduler states: IDLE picks the next pending channel, OFFER holds it until accepted.
    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester after `last`, wrapping modulo N.
module rr_pick
    import edge_arb_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] last_i,
    output logic            any_o,
    output logic [ID_W-1:0] grant_id_o
);

    logic [ID_W-1:0] cand;

    // Walk candidates from farthest to nearest so the nearest requester after last_i wins.
    always_comb begin
        any_o      = |req_i;
        grant_id_o = '0;
        cand       = '0;
        for (int k = int'(N); k >= 1; k--) begin
            cand = ID_W'((int'(last_i) + k) % int'(N));
            if (req_i[cand]) begin
                grant_id_o = cand;
            end
        end
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// Captures rising edges on N level inputs and serialises them onto one valid/ready port.
module edge_event_arbiter
    import edge_arb_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    level,
    input  logic [N-1:0]    chan_en,
    output logic            event_valid,
    output logic [ID_W-1:0] event_id,
    input  logic            event_ready,
    output logic [N-1:0]    pending,
    output logic [N-1:0]    overflow,
    input  logic [N-1:0]    clear_ovf
);

    arb_state_e      state_q, state_d;
    logic [N-1:0]    level_q, level_d;
    logic [N-1:0]    pending_q, pending_d;
    logic [N-1:0]    overflow_q, overflow_d;
    logic            event_valid_q, event_valid_d;
    logic [ID_W-1:0] event_id_q, event_id_d;
    logic [ID_W-1:0] last_q, last_d;

    logic [N-1:0]    rise;
    logic [N-1:0]    accept_vec;
    logic            accept;
    logic            pick_any;
    logic [ID_W-1:0] pick_id;

    // Arbitration only looks at registered pending flags, so a new rise waits one cycle.
    rr_pick #(
        .N    (N),
        .ID_W (ID_W)
    ) u_rr_pick (
        .req_i      (pending_q),
        .last_i     (last_q),
        .any_o      (pick_any),
        .grant_id_o (pick_id)
    );

    // Scheduler: pick in IDLE, hold the offer in OFFER until the consumer takes it.
    always_comb begin
        state_d       = state_q;
        event_valid_d = event_valid_q;
        event_id_d    = event_id_q;
        last_d        = last_q;
        accept        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    event_id_d    = pick_id;
                    event_valid_d = 1'b1;
                    state_d       = OFFER;
                end
            end
            OFFER: begin
                if (event_ready) begin
                    accept        = 1'b1;
                    event_valid_d = 1'b0;
                    last_d        = event_id_q;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Edge detect plus pending/overflow bookkeeping; a rise on the accepted channel survives.
    always_comb begin
        level_d = level;
        rise    = level & ~level_q & chan_en;
        for (int i = 0; i < int'(N); i++) begin
            accept_vec[i] = accept && (event_id_q == ID_W'(i));
        end
        pending_d  = (pending_q & ~accept_vec) | rise;
        // Set has priority over the clear request.
        overflow_d = (overflow_q & ~clear_ovf) | (rise & pending_q & ~accept_vec);
    end

    // State registers; reset drops every pending and offered event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            level_q       <= '0;
            pending_q     <= '0;
            overflow_q    <= '0;
            event_valid_q <= 1'b0;
            event_id_q    <= '0;
            last_q        <= ID_W'(N - 1);
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            pending_q     <= pending_d;
            overflow_q    <= overflow_d;
            event_valid_q <= event_valid_d;
            event_id_q    <= event_id_d;
            last_q        <= last_d;
        end
    end

    assign event_valid = event_valid_q;
    assign event_id    = event_id_q;
    assign pending     = pending_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter with N = 4.
module tb_edge_event_arbiter;

    localparam int unsigned N    = 4;
    localparam int unsigned ID_W = 2;

    logic            clk;
    logic            reset;
    logic [N-1:0]    level;
    logic [N-1:0]    chan_en;
    logic            event_valid;
    logic [ID_W-1:0] event_id;
    logic            event_ready;
    logic [N-1:0]    pending;
    logic [N-1:0]    overflow;
    logic [N-1:0]    clear_ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int grants;
    logic [ID_W-1:0] exp_id;

    edge_event_arbiter #(
        .N    (N),
        .ID_W (ID_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .level       (level),
        .chan_en     (chan_en),
        .event_valid (event_valid),
        .event_id    (event_id),
        .event_ready (event_ready),
        .pending     (pending),
        .overflow    (overflow),
        .clear_ovf   (clear_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b0;
        level       = 4'b0010;
        chan_en     = 4'hF;
        event_ready = 1'b0;
        clear_ovf   = '0;
        tick();
        tick();
        check("rst_valid", 16'(event_valid), 16'h0);
        check("rst_id", 16'(event_id), 16'h0);
        check("rst_pending", 16'(pending), 16'h0);
        check("rst_overflow", 16'(overflow), 16'h0);

        // Reset release with level[1] already high.
        reset = 1'b1;
        tick();
        check("rel_pending", 16'(pending), 16'h2);
        check("rel_valid_early", 16'(event_valid), 16'h0);
        tick();
        check("rel_valid", 16'(event_valid), 16'h1);
        check("rel_id", 16'(event_id), 16'h1);
        tick();
        tick();
        check("rel_hold_valid", 16'(event_valid), 16'h1);
        check("rel_hold_id", 16'(event_id), 16'h1);
        event_ready = 1'b1;
        tick();
        check("rel_accept_valid", 16'(event_valid), 16'h0);
        check("rel_accept_pending", 16'(pending), 16'h0);

        // Fresh reset, then all four channels rise together.
        reset = 1'b0;
        level = '0;
        tick();
        reset = 1'b1;
        tick();
        level = 4'hF;
        tick();
        check("sim_pending", 16'(pending), 16'hF);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("sim_valid_hi", 16'(event_valid), 16'h1);
            check("sim_id", 16'(event_id), 16'(i));
            tick();
            check("sim_valid_gap", 16'(event_valid), 16'h0);
        end
        check("sim_overflow", 16'(overflow), 16'h0);
        check("sim_pending_done", 16'(pending), 16'h0);

        // Lost edge on channel 2 while its offer is stalled.
        event_ready = 1'b0;
        level = 4'b1011;
        tick();
        level = 4'b1111;
        tick();
        check("lost_pending", 16'(pending), 16'h4);
        tick();
        check("lost_offer_id", 16'(event_id), 16'h2);
        level = 4'b1011;
        tick();
        level = 4'b1111;
        tick();
        check("lost_overflow", 16'(overflow), 16'h4);
        level = 4'b1011;
        tick();
        level     = 4'b1111;
        clear_ovf = 4'b0100;
        tick();
        check("lost_set_beats_clear", 16'(overflow), 16'h4);
        clear_ovf = 4'b0100;
        tick();
        check("lost_clear", 16'(overflow), 16'h0);
        clear_ovf = '0;
        check("lost_offer_held", 16'({event_valid, event_id}), 16'h6);

        // Rise on channel 3 in the same cycle its offer is accepted.
        event_ready = 1'b1;
        tick();
        event_ready = 1'b0;
        check("ch2_accepted", 16'(pending), 16'h0);
        level = 4'b0111;
        tick();
        level = 4'b1111;
        tick();
        tick();
        check("rda_offer3", 16'({event_valid, event_id}), 16'h7);
        level = 4'b0111;
        tick();
        level       = 4'b1111;
        event_ready = 1'b1;
        tick();
        check("rda_pending_kept", 16'(pending), 16'h8);
        check("rda_no_overflow", 16'(overflow), 16'h0);
        check("rda_valid_drop", 16'(event_valid), 16'h0);
        event_ready = 1'b0;
        tick();
        check("rda_reoffer", 16'({event_valid, event_id}), 16'h7);
        event_ready = 1'b1;
        tick();
        check("rda_drained", 16'(pending), 16'h0);

        // Fairness between channels 0 and 3; channel 1 disabled but toggling.
        chan_en = 4'b1101;
        level   = '0;
        tick();
        exp_id = 2'd0;
        grants = 0;
        for (int c = 0; c < 20; c++) begin
            level = (c % 2 == 0) ? 4'b1011 : 4'b0000;
            tick();
            check("rr_ch1_idle", 16'(pending[1]), 16'h0);
            if (event_valid) begin
                check("rr_grant_id", 16'(event_id), 16'(exp_id));
                exp_id = (exp_id == 2'd0) ? 2'd3 : 2'd0;
                grants++;
            end
        end
        check("rr_grant_count", 16'(grants), 16'd10);

        // Drain, then three channels pending with an offer stalled.
        chan_en = 4'hF;
        level   = '0;
        repeat (10) tick();
        check("drain_pending", 16'(pending), 16'h0);
        check("drain_valid", 16'(event_valid), 16'h0);
        event_ready = 1'b0;
        level = 4'b1110;
        tick();
        check("mid_pending", 16'(pending), 16'hE);
        tick();
        check("mid_offer", 16'({event_valid, event_id}), 16'h5);
        level = 4'b1100;
        tick();
        level = 4'b1110;
        tick();
        check("mid_overflow1", 16'(overflow[1]), 16'h1);

        // Asynchronous reset in the middle of a clock period.
        #2;
        reset = 1'b0;
        #1;
        check("arst_valid", 16'(event_valid), 16'h0);
        check("arst_id", 16'(event_id), 16'h0);
        check("arst_pending", 16'(pending), 16'h0);
        check("arst_overflow", 16'(overflow), 16'h0);
        chan_en = 4'b1100;
        tick();
        check("arst_hold_pending", 16'(pending), 16'h0);
        reset = 1'b1;
        tick();
        check("regen_pending", 16'(pending), 16'hC);
        tick();
        check("regen_first_grant", 16'({event_valid, event_id}), 16'h6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
